// File: rtl/nn_weight_loader_if.sv
// rtl/nn_weight_loader_if.sv - weight word stream handshake between source and loader
interface nn_weight_loader_if #(
    parameter int data_width = 16
);
    logic                  in_valid;
    logic [data_width-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/nn_weight_loader.sv
// rtl/nn_weight_loader.sv - double-buffered genome weight loader with atomic commit
module nn_weight_loader #(
    parameter int data_width   = 16,
    parameter int weight_count = 58,
    localparam int CW          = $clog2(weight_count),
    localparam int WW          = data_width * weight_count
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    nn_weight_loader_if.slave      in_if,
    output logic [WW-1:0]          weights,
    output logic                   weights_valid,
    output logic                   busy,
    output logic                   done,
    output logic [CW-1:0]          word_count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_in_ready;
    logic            w_busy;
    logic            w_accept;
    logic            w_clear;
    logic            w_last;
    logic [WW-1:0]   r_shadow;
    logic [WW-1:0]   r_weights;
    logic            r_weights_valid;
    logic            r_done;
    logic [CW-1:0]   r_word_count;

    assign w_last = (r_word_count == CW'(weight_count - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // abort outranks start, and both outrank a word arriving the same cycle
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_accept   = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_LOAD;
                    w_clear = 1'b1;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (abort) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else if (start) begin
                    w_clear = 1'b1;
                end else if (in_if.in_valid) begin
                    w_accept = 1'b1;
                    if (w_last) w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_shadow        <= '0;
            r_weights       <= '0;
            r_weights_valid <= 1'b0;
            r_done          <= 1'b0;
            r_word_count    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_clear) begin
                r_word_count <= '0;
            end else if (w_accept) begin
                r_shadow[int'(r_word_count) * data_width +: data_width] <= in_if.in_data;
                r_word_count <= w_last ? '0 : r_word_count + 1'b1;
            end
            // downstream only ever sees a fully assembled genome
            if (r_state == S_COMMIT) begin
                r_weights       <= r_shadow;
                r_weights_valid <= 1'b1;
                r_done          <= 1'b1;
            end
        end
    end

    assign in_if.in_ready = w_in_ready;
    assign busy           = w_busy;
    assign weights        = r_weights;
    assign weights_valid  = r_weights_valid;
    assign done           = r_done;
    assign word_count     = r_word_count;
endmodule

// File: tb/tb_nn_weight_loader.sv
// tb/tb_nn_weight_loader.sv - directed self-checking bench for nn_weight_loader
module tb_nn_weight_loader;
    localparam int DW = 16;
    localparam int N  = 58;
    localparam int CW = $clog2(N);
    localparam int WW = DW * N;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] weights;
    logic          weights_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;

    nn_weight_loader_if #(.data_width(DW)) in_if ();

    nn_weight_loader #(.data_width(DW), .weight_count(N)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .abort         (abort),
        .in_if         (in_if.slave),
        .weights       (weights),
        .weights_valid (weights_valid),
        .busy          (busy),
        .done          (done),
        .word_count    (word_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_weights(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int k = N - 1; k >= 0; k--)
            if (got[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: word %0d got %0h expected %0h at %0t",
                     name, bad, got[bad*DW +: DW], exp[bad*DW +: DW], $time);
        end
    endtask

    // Model: a load is a list of accepted words; a full list becomes a pending genome
    // that is published one cycle later.
    logic [DW-1:0] m_words[$];
    logic [WW-1:0] m_pending = '0;
    logic [WW-1:0] m_weights = '0;
    bit            m_loading = 0;
    bit            m_committing = 0;
    bit            m_wv = 0;
    bit            m_done = 0;

    task automatic model_step();
        if (!resetn) begin
            m_words.delete();
            m_pending    = '0;
            m_weights    = '0;
            m_loading    = 0;
            m_committing = 0;
            m_wv         = 0;
            m_done       = 0;
            return;
        end
        m_done = 0;
        if (m_committing) begin
            m_weights    = m_pending;
            m_wv         = 1;
            m_done       = 1;
            m_committing = 0;
        end else if (m_loading) begin
            if (abort) begin
                m_loading = 0;
                m_words.delete();
            end else if (start) begin
                m_words.delete();
            end else if (in_if.in_valid) begin
                m_words.push_back(in_if.in_data);
                if (m_words.size() == N) begin
                    for (int k = 0; k < N; k++) m_pending[k*DW +: DW] = m_words[k];
                    m_words.delete();
                    m_loading    = 0;
                    m_committing = 1;
                end
            end
        end else if (start) begin
            m_loading = 1;
            m_words.delete();
        end
    endtask

    initial forever begin
        @(posedge clock or negedge resetn);
        model_step();
    end

    bit cmp_on = 0;
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("in_ready", in_if.in_ready, m_loading);
            chk("busy", busy, m_loading | m_committing);
            chk("word_count", word_count, m_words.size());
            chk("done", done, m_done);
            chk("weights_valid", weights_valid, m_wv);
            chk_weights("weights", weights, m_weights);
        end
    end

    int done_seen = 0;
    int rdy_seen = 0;
    always @(negedge clock) begin
        if (done) done_seen <= done_seen + 1;
        if (in_if.in_ready) rdy_seen <= rdy_seen + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        in_if.in_valid = 1'b1;
        in_if.in_data  = v;
        tick();
        in_if.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("done_within_budget", done, 1'b1);
    endtask

    int d0, r0;

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        #2;
        chk("reset_weights", weights, 0);
        chk("reset_ready", in_if.in_ready, 0);
        chk("reset_busy", busy, 0);
        tick();
        resetn = 1'b1;
        cmp_on = 1;
        tick();

        // basic load 0x0001..0x003A
        d0 = done_seen;
        r0 = rdy_seen;
        pulse_start();
        for (int i = 1; i <= N; i++) send(DW'(i));
        wait_done();
        tick();
        chk("basic_lsw", weights[15:0], 16'h0001);
        chk("basic_msw", weights[927:912], 16'h003A);
        chk("basic_wv", weights_valid, 1);
        chk("basic_done_once", done_seen - d0, 1);
        chk("basic_ready_cycles", rdy_seen - r0, N);

        // abort genome B after 20 words
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 20; i++) send(DW'(16'h0200 + i));
        chk("abort_wc_before", word_count, 20);
        abort = 1'b1;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'hBEEF;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        in_if.in_valid = 1'b0;
        repeat (3) tick();
        chk("abort_busy", busy, 0);
        chk("abort_wc", word_count, 0);
        chk("abort_keep_lsw", weights[15:0], 16'h0001);
        chk("abort_no_done", done_seen - d0, 0);

        // gapped stream
        pulse_start();
        for (int i = 0; i < N; i++) begin
            send(DW'(16'h0100 + i));
            tick();
            if (i == 9) chk("gap_wc10", word_count, 10);
        end
        wait_done();
        tick();
        chk("gap_lsw", weights[15:0], 16'h0100);
        chk("gap_msw", weights[927:912], 16'h0139);

        // restart at word 30, then commit-time start/abort must be ignored
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 30; i++) send(DW'(16'h0300 + i));
        start = 1'b1;
        send(16'hDEAD);
        start = 1'b0;
        chk("restart_wc", word_count, 0);
        for (int i = 0; i < N; i++) send(DW'(16'h0400 + i));
        chk("commit_busy", busy, 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("commit_done", done, 1);
        tick();
        chk("restart_lsw", weights[15:0], 16'h0400);
        chk("restart_msw", weights[927:912], 16'h0439);
        chk("restart_done_once", done_seen - d0, 1);
        chk("restart_idle", busy, 0);

        // reset mid-load at word 40
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < 40; i++) send(DW'(16'h0700 + i));
        resetn = 1'b0;
        #1;
        chk("rst_async_weights", weights, 0);
        chk("rst_async_wv", weights_valid, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ready", in_if.in_ready, 0);
        chk("rst_async_wc", word_count, 0);
        chk("rst_async_done", done, 0);
        tick();
        resetn = 1'b1;
        repeat (2) tick();
        chk("rst_no_done", done_seen - d0, 0);

        // back-to-back loads
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < N; i++) send(DW'(16'h0500 + i));
        wait_done();
        pulse_start();
        for (int i = 0; i < 30; i++) send(DW'(16'h0600 + i));
        chk("b2b_hold_lsw", weights[15:0], 16'h0500);
        for (int i = 30; i < N; i++) send(DW'(16'h0600 + i));
        chk("b2b_hold_msw", weights[927:912], 16'h0539);
        wait_done();
        chk("b2b_new_lsw", weights[15:0], 16'h0600);
        chk("b2b_new_msw", weights[927:912], 16'h0639);
        tick();
        chk("b2b_done_twice", done_seen - d0, 2);

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
